// File: rtl/mmio_uart_tx_pkg.sv
// Shared definitions for the memory-mapped UART transmitter: register
// offsets relative to BASE_ADDR, STATUS bit positions, the transmit FSM
// state type and a helper that packs the STATUS word.
package uart_pkg;

    // Word offsets from BASE_ADDR
    localparam int OFF_TXDATA = 0;
    localparam int OFF_STATUS = 1;
    localparam int OFF_BAUD   = 2;

    // STATUS bit positions; the FIFO count occupies [ST_CNT_LSB+7:ST_CNT_LSB]
    localparam int ST_FULL    = 0;
    localparam int ST_EMPTY   = 1;
    localparam int ST_BUSY    = 2;
    localparam int ST_OVF     = 3;
    localparam int ST_CNT_LSB = 4;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } tx_state_e;

    function automatic logic [31:0] pack_status(input logic [7:0] cnt,
                                                 input logic       ovf,
                                                 input logic       busy,
                                                 input logic       empty,
                                                 input logic       full);
        logic [31:0] w;
        w = '0;
        w[ST_CNT_LSB +: 8] = cnt;
        w[ST_OVF]          = ovf;
        w[ST_BUSY]         = busy;
        w[ST_EMPTY]        = empty;
        w[ST_FULL]         = full;
        return w;
    endfunction

endpackage

// File: rtl/mmio_uart_tx_if.sv
// CPU data-port bus as seen by the UART transmitter.
//   dataAddress  word address            (master -> slave)
//   writeDataIn  store data              (master -> slave)
//   dataWrEn     one-cycle store strobe  (master -> slave)
//   readDataOut  registered load data    (slave -> master)
interface mmio_uart_tx_if;
    logic [13:0] dataAddress;
    logic [31:0] writeDataIn;
    logic        dataWrEn;
    logic [31:0] readDataOut;

    modport master (
        output dataAddress,
        output writeDataIn,
        output dataWrEn,
        input  readDataOut
    );

    modport slave (
        input  dataAddress,
        input  writeDataIn,
        input  dataWrEn,
        output readDataOut
    );
endinterface

// File: rtl/mmio_uart_tx_sync_fifo.sv
// Synchronous first-word-fall-through FIFO.
//   clk, rst   clock / synchronous active-high reset
//   push_i     write wdata_i (ignored while full)
//   wdata_i    data to write
//   pop_i      advance past the head entry (ignored while empty)
//   rdata_o    head entry, valid whenever empty_o is low
//   full_o     DEPTH entries held
//   empty_o    no entries held
//   count_o    number of entries held (one bit wider than the pointers)
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         wdata_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         rdata_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [AW:0]      count_q;
    logic             do_push, do_pop;

    // Full/empty come from the registered count, so a push while full is
    // dropped even if a pop frees a slot on the same edge.
    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];

    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;

    // Storage carries no reset; only pointers and count define validity.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end
endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter on the CPU data port.
//   clk, rst     system clock / synchronous active-high reset
//   bus          CPU data port (slave): stores to TXDATA/STATUS/BAUDDIV,
//                registered 1-cycle read data for the mapped words, else 0
//   uart_tx      serial line, idle high, registered
//   tx_irq       high while the FIFO is empty and the shifter idle, registered
// Registers (word addresses): BASE TXDATA (write pushes a byte),
// BASE+1 STATUS ({cnt[11:4], ovf, busy, empty, full}, write bit3 clears ovf),
// BASE+2 BAUDDIV (clocks per bit, 0 stored as 1).
module mmio_uart_tx
    import uart_pkg::*;
#(
    parameter logic [13:0] BASE_ADDR   = 14'h3FF8,
    parameter int          FIFO_DEPTH  = 8,
    parameter int          DIV_WIDTH   = 16,
    parameter int          DEFAULT_DIV = 434
) (
    input  logic        clk,
    input  logic        rst,
    mmio_uart_tx_if.slave bus,
    output logic        uart_tx,
    output logic        tx_irq
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    localparam logic [13:0] ADDR_TX   = BASE_ADDR + 14'(OFF_TXDATA);
    localparam logic [13:0] ADDR_STAT = BASE_ADDR + 14'(OFF_STATUS);
    localparam logic [13:0] ADDR_BAUD = BASE_ADDR + 14'(OFF_BAUD);

    // Address decode
    logic sel_tx, sel_stat, sel_baud;
    logic wr_tx, wr_stat, wr_baud;

    assign sel_tx   = (bus.dataAddress == ADDR_TX);
    assign sel_stat = (bus.dataAddress == ADDR_STAT);
    assign sel_baud = (bus.dataAddress == ADDR_BAUD);
    assign wr_tx    = bus.dataWrEn & sel_tx;
    assign wr_stat  = bus.dataWrEn & sel_stat;
    assign wr_baud  = bus.dataWrEn & sel_baud;

    // FIFO
    logic [7:0]    fifo_rdata;
    logic          fifo_full, fifo_empty, fifo_pop;
    logic [CW-1:0] fifo_count;

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (wr_tx),
        .wdata_i (bus.writeDataIn[7:0]),
        .pop_i   (fifo_pop),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    // State
    tx_state_e            state_q;
    logic [DIV_WIDTH-1:0] div_q;        // programmed divisor
    logic [DIV_WIDTH-1:0] frame_div_q;  // divisor frozen for the current frame
    logic [DIV_WIDTH-1:0] baud_cnt_q;
    logic [2:0]           bit_idx_q;
    logic [7:0]           shift_q;
    logic                 ovf_q;
    logic                 tx_q;
    logic                 irq_q;
    logic [31:0]          rdata_q;

    logic                 baud_last;
    logic                 busy;
    logic [DIV_WIDTH-1:0] div_wr_val;
    logic [7:0]           cnt8;
    logic [31:0]          rd_mux;

    assign baud_last = (baud_cnt_q == frame_div_q - DIV_WIDTH'(1));
    assign busy      = (state_q != IDLE);

    // A new frame starts straight from IDLE or at the last stop-bit clock,
    // which is what keeps back-to-back frames gapless.
    assign fifo_pop  = ~fifo_empty &
                       ((state_q == IDLE) || ((state_q == STOP) && baud_last));

    assign div_wr_val = (bus.writeDataIn[DIV_WIDTH-1:0] == '0) ?
                        DIV_WIDTH'(1) : bus.writeDataIn[DIV_WIDTH-1:0];

    assign cnt8 = 8'(fifo_count);

    always_comb begin
        rd_mux = '0;
        if (!bus.dataWrEn) begin
            if (sel_stat)
                rd_mux = pack_status(cnt8, ovf_q, busy, fifo_empty, fifo_full);
            else if (sel_baud)
                rd_mux = 32'(div_q);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            div_q       <= DIV_WIDTH'(DEFAULT_DIV);
            frame_div_q <= DIV_WIDTH'(DEFAULT_DIV);
            baud_cnt_q  <= '0;
            bit_idx_q   <= '0;
            shift_q     <= '0;
            ovf_q       <= 1'b0;
            tx_q        <= 1'b1;
            irq_q       <= 1'b1;
            rdata_q     <= '0;
        end else begin
            rdata_q <= rd_mux;

            if (wr_baud) div_q <= div_wr_val;

            if (wr_tx && fifo_full)
                ovf_q <= 1'b1;
            else if (wr_stat && bus.writeDataIn[ST_OVF])
                ovf_q <= 1'b0;

            // Line and irq follow the current state, one clock behind it
            case (state_q)
                START:   tx_q <= 1'b0;
                DATA:    tx_q <= shift_q[0];
                default: tx_q <= 1'b1;
            endcase
            irq_q <= fifo_empty & ~busy;

            case (state_q)
                IDLE: begin
                    if (!fifo_empty) begin
                        state_q     <= START;
                        frame_div_q <= div_q;
                        shift_q     <= fifo_rdata;
                        baud_cnt_q  <= '0;
                    end
                end
                START: begin
                    if (baud_last) begin
                        state_q    <= DATA;
                        baud_cnt_q <= '0;
                        bit_idx_q  <= '0;
                    end else begin
                        baud_cnt_q <= baud_cnt_q + 1'b1;
                    end
                end
                DATA: begin
                    if (baud_last) begin
                        baud_cnt_q <= '0;
                        shift_q    <= {1'b0, shift_q[7:1]};
                        if (bit_idx_q == 3'd7) state_q <= STOP;
                        else                   bit_idx_q <= bit_idx_q + 1'b1;
                    end else begin
                        baud_cnt_q <= baud_cnt_q + 1'b1;
                    end
                end
                STOP: begin
                    if (baud_last) begin
                        baud_cnt_q <= '0;
                        if (!fifo_empty) begin
                            state_q     <= START;
                            frame_div_q <= div_q;
                            shift_q     <= fifo_rdata;
                        end else begin
                            state_q <= IDLE;
                        end
                    end else begin
                        baud_cnt_q <= baud_cnt_q + 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Store data bits not decoded by any register
    logic unused_wdata;
    assign unused_wdata = ^bus.writeDataIn;

    assign bus.readDataOut = rdata_q;
    assign uart_tx         = tx_q;
    assign tx_irq          = irq_q;

endmodule
